seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of NDIG shared-segment seven-segment digits.
- Holds a writable digit buffer and walks a one-hot, active-low digit select across the bank at a programmable rate.
- Decodes the selected nibble to active-low segments using the team's standard hex font.
- Adds per-digit enable, leading-zero blanking, per-digit blink and a frame-done pulse; sits between the lab's counter/ALU datapaths and the board display pins.

Parameters:
- NDIG, 8, number of digits scanned (2..16).
- TICK_DIV, 50000, clk cycles per digit slot (>=2).
- BLINK_FRAMES, 64, full scan frames per blink half-period (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe for digit buffer
- wr_addr  in  clog2(NDIG)  digit index to write (0 = rightmost)
- wr_data  in  4  hex nibble to store
- dig_en  in  NDIG  per-digit display enable (0 = blank)
- lz_blank  in  1  suppress leading zeros
- blink_mask  in  NDIG  per-digit blink enable
- o_an  out  NDIG  digit select, active-low, one-hot-zero
- o_seg  out  8  segments {a,b,c,d,e,f,g,dp}, active-low; dp always 1
- frame_done  out  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset values (asynchronous assert, synchronous-safe deassert):
  - digit buffer all 0, div_cnt 0, scan idx 0, blink counter 0, blink_phase 0.
  - o_an all 1s, o_seg 8'hFF, frame_done 0.
- Divider: div_cnt counts 0..TICK_DIV-1 and wraps. tick is asserted when div_cnt == TICK_DIV-1.
- Scan index: advances on tick, wrapping NDIG-1 -> 0.
- frame_done: registered, high for exactly one cycle, in the cycle after the tick that wraps idx to 0.
- Blink:
  - A frame counter counts frame_done pulses 0..BLINK_FRAMES-1.
  - blink_phase toggles on wrap.
  - When blink_phase == 1, digits with blink_mask set are blanked.
- Buffer write: synchronous. On wr_en, buf[wr_addr] <= wr_data. An out-of-range wr_addr (NDIG not a power of 2) is ignored.
- Blank condition for digit i: any of the following makes it blank.
  - dig_en[i] == 0.
  - Blink active for i (blink_mask[i] == 1 and blink_phase == 1).
  - Leading zero: lz_blank == 1, i != 0, and buf[j] == 0 for every j with i <= j <= NDIG-1. Digit 0 is never LZ-blanked, so all-zero shows a single "0".
- Output stage: registered, 1-cycle latency from idx/buffer state.
  - Each cycle: o_an <= ~(1 << idx).
  - o_seg <= blank ? 8'hFF : ~font(buf[idx]).
- Font, active-high before inversion, MSB = a:
  - 0 FC, 1 60, 2 DA, 3 F2, 4 66, 5 B6, 6 BE, 7 E0
  - 8 FE, 9 F6, A EE, b 3E, C 9C, d 7A, E 9E, F 8E
- Blanked digits still drive their o_an low (slot timing is uniform); only o_seg goes to FF.
- Simultaneous write and scan of the same digit: the output in that cycle reflects the old value; the new value appears on the next clock edge.
- Input changes: dig_en, lz_blank and blink_mask changes take effect on the next output register update. There is no handshake.
- Reset mid-scan: outputs go to the idle values immediately. After release, scanning restarts at idx 0 with div_cnt 0.

Test Plan:
- Reset: (TICK_DIV=4, NDIG=4, BLINK_FRAMES=2) hold rst_n=0 -> o_an=4'b1111, o_seg=FF, frame_done=0. Release -> first o_an=4'b1110, o_seg=~FC = 03.
- Scan order: write buf = {3,2,1,0} (idx 3..0), dig_en=F.
  - o_an steps 1110,1101,1011,0111 every 4 clks.
  - o_seg steps 03,9F,25,0D.
  - frame_done pulses once per 16 clks, after the 0111 slot.
- Leading zeros: buf={0,0,5,0}, lz_blank=1 -> slots 3,2 show FF; slot 1 shows 49; slot 0 shows 03. With buf all 0 -> only slot 0 shows 03.
- Blink: blink_mask=4'b0001 -> slot 0 alternates between glyph and FF every 2 frames (32 clks). Other slots are unaffected.
- Write collision: write wr_addr=idx with 4'hA in the cycle the slot is displayed -> o_seg shows the old glyph for 1 cycle, then ~EE = 11.
- Mid-scan reset: assert rst_n=0 while at idx 2 -> outputs go idle at once. After release, scan resumes at idx 0 and the buffer reads back as all 0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for NDIG shared-segment seven-segment digits.
// Walks an active-low digit select and drives active-low hex glyphs with blanking and blink.
module seg_scan_ctrl #(
    parameter int NDIG         = 8,
    parameter int TICK_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [$clog2(NDIG)-1:0] wr_addr,
    input  logic [3:0]              wr_data,
    input  logic [NDIG-1:0]         dig_en,
    input  logic                    lz_blank,
    input  logic [NDIG-1:0]         blink_mask,
    output logic [NDIG-1:0]         o_an,
    output logic [7:0]              o_seg,
    output logic                    frame_done
);

    localparam int AW = $clog2(NDIG);
    localparam int DW = $clog2(TICK_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic            blink_phase_q, blink_phase_d;
    logic            frame_done_q, frame_done_d;
    logic [3:0]      dig_buf_q [NDIG];
    logic [3:0]      dig_buf_d [NDIG];
    logic [NDIG-1:0] an_q, an_d;
    logic [7:0]      seg_q, seg_d;

    logic            tick;
    logic            zero_acc;
    logic [NDIG-1:0] zero_from;
    logic            blank;

    function automatic logic [7:0] font(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0: g = 8'hFC;
            4'h1: g = 8'h60;
            4'h2: g = 8'hDA;
            4'h3: g = 8'hF2;
            4'h4: g = 8'h66;
            4'h5: g = 8'hB6;
            4'h6: g = 8'hBE;
            4'h7: g = 8'hE0;
            4'h8: g = 8'hFE;
            4'h9: g = 8'hF6;
            4'hA: g = 8'hEE;
            4'hB: g = 8'h3E;
            4'hC: g = 8'h9C;
            4'hD: g = 8'h7A;
            4'hE: g = 8'h9E;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

    // Slot divider, scan index and frame/blink bookkeeping.
    always_comb begin
        tick          = (div_cnt_q == DW'(TICK_DIV - 1));
        div_cnt_d     = tick ? '0 : div_cnt_q + 1'b1;
        idx_d         = idx_q;
        if (tick) begin
            idx_d = (idx_q == AW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
        end
        frame_done_d  = tick && (idx_q == AW'(NDIG - 1));
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_done_q) begin
            if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Addresses at or above NDIG match no entry, so such writes fall away.
    always_comb begin
        for (int i = 0; i < NDIG; i++) begin
            dig_buf_d[i] = dig_buf_q[i];
            if (wr_en && (wr_addr == AW'(i))) begin
                dig_buf_d[i] = wr_data;
            end
        end
    end

    // zero_from[i] is set when digit i and every digit to its left hold zero.
    always_comb begin
        zero_acc  = 1'b1;
        zero_from = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zero_acc     = zero_acc & (dig_buf_q[i] == 4'h0);
            zero_from[i] = zero_acc;
        end
    end

    always_comb begin
        blank = !dig_en[idx_q]
              || (blink_mask[idx_q] && blink_phase_q)
              || (lz_blank && (idx_q != '0) && zero_from[idx_q]);
        an_d  = ~(NDIG'(1) << idx_q);
        seg_d = blank ? 8'hFF : ~font(dig_buf_q[idx_q]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q     <= '0;
            idx_q         <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            frame_done_q  <= 1'b0;
            an_q          <= '1;
            seg_q         <= 8'hFF;
            for (int i = 0; i < NDIG; i++) begin
                dig_buf_q[i] <= 4'h0;
            end
        end else begin
            div_cnt_q     <= div_cnt_d;
            idx_q         <= idx_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            frame_done_q  <= frame_done_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            for (int i = 0; i < NDIG; i++) begin
                dig_buf_q[i] <= dig_buf_d[i];
            end
        end
    end

    assign o_an       = an_q;
    assign o_seg      = seg_q;
    assign frame_done = frame_done_q;

endmodule
